// File: rtl/l1_ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM types for the L1 slave family.
package l1_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int WAIT_MAX = 15;
  localparam int WAIT_CW  = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Address-phase control carried into the data phase.
  typedef struct packed {
    logic       write;
    logic       err;
    logic [3:0] strb;
  } ahb_ctrl_t;

endpackage

// File: rtl/l1_ahb_slv_bytelane.sv
// Byte-lane strobe and misalignment decode from HSIZE and the low address bits.
module l1_ahb_slv_bytelane
  import l1_ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb     = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'hF;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/l1_ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR.
// Optional user-write rejection when L1_AHB_SLV_PRIV_CHK_EN is defined.
module l1_ahb_sram_slave
  import l1_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [3:0]  HPROTS,
  input  logic        HREADYS,
  input  logic [31:0] HWDATAS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic [31:0] HRDATAS
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [WAIT_CW-1:0] WS_RELOAD = WAIT_CW'(WAIT_STATES - 1);

  logic [31:0] mem [DEPTH];

  slv_state_e            state_q, state_d;
  logic [WAIT_CW-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  ahb_ctrl_t             ctrl_q, ctrl_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;

  logic       accept;
  logic [3:0] strb_ap;
  logic       misalign_ap;
  logic       hi_err, size_err, priv_err, err_ap;
  logic       unused_prot;
  logic       wr_en, rd_en;

  l1_ahb_slv_bytelane u_lane (
    .size     (HSIZES),
    .addr_lo  (HADDRS[1:0]),
    .strb     (strb_ap),
    .misalign (misalign_ap)
  );

  assign accept   = HSELS & HREADYS &
                    ((HTRANSS == HTRANS_NONSEQ) | (HTRANSS == HTRANS_SEQ));
  assign hi_err   = |HADDRS[31:ADDR_WIDTH+2];
  assign size_err = HSIZES > HSIZE_WORD;

`ifdef L1_AHB_SLV_PRIV_CHK_EN
  assign priv_err    = HWRITES & ~HPROTS[1];
  assign unused_prot = ^{HPROTS[3:2], HPROTS[0]};
`else
  assign priv_err    = 1'b0;
  assign unused_prot = ^HPROTS;
`endif

  assign err_ap = hi_err | size_err | misalign_ap | priv_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all close a data phase with HREADYOUTS high.
        if (accept) begin
          addr_d = HADDRS[ADDR_WIDTH+1:2];
          ctrl_d = '{write: HWRITES, err: err_ap, strb: strb_ap};
          if (err_ap)                state_d = ST_ERR1;
          else if (WAIT_STATES == 0) state_d = ST_DATA;
          else begin
            state_d = ST_WAIT;
            cnt_d   = WS_RELOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      ctrl_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      ctrl_q      <= ctrl_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign wr_en = (state_q == ST_DATA) & ctrl_q.write & ~ctrl_q.err;
  assign rd_en = (state_q == ST_DATA) & ~ctrl_q.write;

  // Commit at the edge ending the write's data phase so a back-to-back read sees it.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ctrl_q.strb[b]) mem[addr_q][8*b +: 8] <= HWDATAS[8*b +: 8];
      end
    end
  end

  assign HREADYOUTS = hreadyout_q;
  assign HRESPS     = hresp_q;
  assign HRDATAS    = rd_en ? mem[addr_q] : 32'h0;

endmodule

// File: tb/tb_l1_ahb_sram_slave.sv
// Directed bench: one zero-wait and one 3-wait instance on a shared master bus.
module tb_l1_ahb_sram_slave;
  import l1_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel = 1'b0, tgt = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [3:0]  hprot = 4'b0011;
  logic        ro0, rs0, ro3, rs3, hready;
  logic [31:0] rd0, rd3;
  int          n_cmp = 0, n_bad = 0, n;

  always #5 HCLK = ~HCLK;
  assign hready = tgt ? ro3 : ro0;

  l1_ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(hsel & ~tgt), .HADDRS(haddr),
    .HTRANSS(htrans), .HWRITES(hwrite), .HSIZES(hsize), .HPROTS(hprot),
    .HREADYS(hready), .HWDATAS(hwdata), .HREADYOUTS(ro0), .HRESPS(rs0), .HRDATAS(rd0));

  l1_ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(hsel & tgt), .HADDRS(haddr),
    .HTRANSS(htrans), .HWRITES(hwrite), .HSIZES(hsize), .HPROTS(hprot),
    .HREADYS(hready), .HWDATAS(hwdata), .HREADYOUTS(ro3), .HRESPS(rs3), .HRDATAS(rd3));

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  task automatic aph(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [3:0] p);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = w; hsize = sz; haddr = a; hprot = p;
  endtask

  task automatic idle;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts HREADYOUTS-low cycles of the 3-wait instance, bounded.
  task automatic wait3(output int cnt);
    cnt = 0;
    while (ro3 !== 1'b1 && cnt < 20) begin
      cnt++;
      tick;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick; tick;
    chk("rst_rdy0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_rdy3", 32'(ro3), 32'd1);
    HRESETn = 1'b1;

    // write then read, zero wait
    aph(1'b1, HSIZE_WORD, 32'h10, 4'b0011); tick;
    chk("wr_dp_rdy", 32'(ro0), 32'd1);
    chk("wr_dp_rdata", rd0, 32'h0);
    hwdata = 32'hDEADBEEF; aph(1'b0, HSIZE_WORD, 32'h10, 4'b0011); tick;
    chk("rd_rdy", 32'(ro0), 32'd1);
    chk("rd_resp", 32'(rs0), 32'd0);
    chk("rd_data", rd0, 32'hDEADBEEF);
    idle; tick;
    chk("idle_rdata", rd0, 32'h0);

    // byte / halfword strobes
    aph(1'b1, HSIZE_WORD, 32'h20, 4'b0011); tick;
    hwdata = 32'h11223344; aph(1'b1, HSIZE_BYTE, 32'h21, 4'b0011); tick;
    hwdata = 32'h0000AA00; aph(1'b1, HSIZE_HALF, 32'h22, 4'b0011); tick;
    hwdata = 32'hBBCC0000; aph(1'b0, HSIZE_WORD, 32'h20, 4'b0011); tick;
    chk("strb_data", rd0, 32'hBBCCAA44);
    idle; tick;

    // misaligned word write -> two-cycle error, then read accepted in ERR2
    aph(1'b1, HSIZE_WORD, 32'h22, 4'b0011); tick;
    chk("err1_rdy", 32'(ro0), 32'd0);
    chk("err1_resp", 32'(rs0), 32'd1);
    hwdata = 32'h99999999; idle; tick;
    chk("err2_rdy", 32'(ro0), 32'd1);
    chk("err2_resp", 32'(rs0), 32'd1);
    aph(1'b0, HSIZE_WORD, 32'h20, 4'b0011); tick;
    chk("post_err_resp", 32'(rs0), 32'd0);
    chk("post_err_data", rd0, 32'hBBCCAA44);

    // out-of-range address, accepted straight from DATA
    aph(1'b0, HSIZE_WORD, 32'h0001_0000, 4'b0011); tick;
    chk("oor_err1_rdy", 32'(ro0), 32'd0);
    chk("oor_err1_resp", 32'(rs0), 32'd1);
    chk("oor_rdata", rd0, 32'h0);
    idle; tick;
    chk("oor_err2_resp", 32'(rs0), 32'd1);
    tick;
    chk("oor_idle_rdy", 32'(ro0), 32'd1);
    chk("oor_idle_resp", 32'(rs0), 32'd0);

    // misaligned halfword and oversize transfer
    aph(1'b0, HSIZE_HALF, 32'h21, 4'b0011); tick;
    chk("half_mis_resp", 32'(rs0), 32'd1);
    idle; tick; tick;
    aph(1'b0, 3'b011, 32'h20, 4'b0011); tick;
    chk("size_err_resp", 32'(rs0), 32'd1);
    idle; tick; tick;

    // privileged write OKAY, then user write
    aph(1'b1, HSIZE_WORD, 32'h40, 4'b0011); tick;
    chk("priv_wr_resp", 32'(rs0), 32'd0);
    chk("priv_wr_rdy", 32'(ro0), 32'd1);
    hwdata = 32'h77777777; aph(1'b1, HSIZE_WORD, 32'h40, 4'b0001); tick;
`ifdef L1_AHB_SLV_PRIV_CHK_EN
    chk("user_wr_rdy", 32'(ro0), 32'd0);
    chk("user_wr_resp", 32'(rs0), 32'd1);
    hwdata = 32'h66666666; idle; tick;
    aph(1'b0, HSIZE_WORD, 32'h40, 4'b0011); tick;
    chk("user_wr_data", rd0, 32'h77777777);
`else
    chk("user_wr_rdy", 32'(ro0), 32'd1);
    chk("user_wr_resp", 32'(rs0), 32'd0);
    hwdata = 32'h66666666; aph(1'b0, HSIZE_WORD, 32'h40, 4'b0011); tick;
    chk("user_wr_data", rd0, 32'h66666666);
`endif
    idle; tick;

    // three wait states
    tgt = 1'b1;
    aph(1'b1, HSIZE_WORD, 32'h10, 4'b0011); tick;
    chk("ws_wr_rdy", 32'(ro3), 32'd0);
    hwdata = 32'hCAFEF00D; idle; wait3(n);
    chk("ws_wr_lowcnt", 32'(n), 32'd3);
    chk("ws_wr_resp", 32'(rs3), 32'd0);
    aph(1'b0, HSIZE_WORD, 32'h10, 4'b0011); tick;
    wait3(n);
    chk("ws_rd_lowcnt", 32'(n), 32'd3);
    chk("ws_rd_data", rd3, 32'hCAFEF00D);
    tick;
    idle; wait3(n);
    chk("ws_rd2_lowcnt", 32'(n), 32'd3);
    chk("ws_rd2_data", rd3, 32'hCAFEF00D);
    tick;
    chk("ws_idle_rdata", rd3, 32'h0);

    // reset during a wait-state write
    aph(1'b1, HSIZE_WORD, 32'h30, 4'b0011); tick;
    hwdata = 32'h0BADCAFE; idle; wait3(n); tick;
    aph(1'b1, HSIZE_WORD, 32'h30, 4'b0011); tick;
    hwdata = 32'h55555555; idle; tick;
    chk("rst_mid_pre_rdy", 32'(ro3), 32'd0);
    HRESETn = 1'b0; #1;
    chk("rst_mid_rdy", 32'(ro3), 32'd1);
    chk("rst_mid_resp", 32'(rs3), 32'd0);
    chk("rst_mid_rdata", rd3, 32'h0);
    tick;
    HRESETn = 1'b1;
    aph(1'b0, HSIZE_WORD, 32'h30, 4'b0011); tick;
    idle; wait3(n);
    chk("rst_mid_old_data", rd3, 32'h0BADCAFE);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
